despachador_destinos_externos: RTL and testbench
================================================

Name: despachador_destinos_externos

Overview:
- Sequencer that sits directly downstream of the external-destination queue ROM.
- Steps the queue address and paces the reads with an inter-request interval counter.
- Hands each 2-bit floor code to the elevator controller over a valid/ready handshake.
- Signals completion, or wraps back to entry 0, once every queue entry has been issued.

Parameters:
- NUM_DESTINOS, 10, number of valid queue entries (addresses 0..NUM_DESTINOS-1).
- INTERVALO, 50, idle clock cycles between the end of one handshake and the next ROM read (>=1).
- CICLICO, 0, 1 = wrap address to 0 after the last entry; 0 = stop in FIN.
- ADDR_W, 8, address width toward the queue.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- iniciar  input  1  one-cycle start pulse; ignored unless in IDLE or FIN.
- address  output  ADDR_W  queue read address.
- dato_cola  input  2  floor code returned by the queue (combinational from address). Encoding: 00=-1, 01=1, 10=2, 11=3.
- destino_valid  output  1  request valid toward the elevator controller.
- destino_piso  output  2  floor code; held stable while destino_valid=1.
- destino_ready  input  1  controller accepts the request.
- ocupado  output  1  high in every state except IDLE and FIN.
- fin  output  1  high while in FIN.
- emitidos  output  ADDR_W  count of completed handshakes since the last start.

Behaviour:
- Reset (async, active-high): all outputs 0; state=IDLE; address=0; interval counter=0.
- IDLE: waits for iniciar=1. On iniciar: address<=0, emitidos<=0, go LEER.
- LEER (1 cycle): address is already stable; register destino_piso<=dato_cola; go OFRECER.
  - Latency: first destino_valid=1 appears exactly 2 cycles after the iniciar edge.
- OFRECER: destino_valid=1. Hold destino_piso and address until destino_ready=1 is sampled with valid high.
  - On handshake: emitidos<=emitidos+1; valid<=0 next cycle.
  - If address==NUM_DESTINOS-1:
    - CICLICO=1: address<=0, go ESPERA.
    - CICLICO=0: go FIN.
  - Otherwise: address<=address+1, go ESPERA.
  - destino_ready while valid=0 is ignored.
- ESPERA: counter loads INTERVALO-1 on entry and decrements each cycle. Go LEER on the cycle the counter equals 0, so exactly INTERVALO cycles elapse with valid=0.
- FIN: fin=1; address holds at NUM_DESTINOS-1.
  - iniciar restarts the sequence as from IDLE.
  - fin drops on the cycle the FSM enters LEER.
- Arithmetic: emitidos saturates at all-ones and never wraps. Address increments are modulo NUM_DESTINOS, never 2^ADDR_W.
- iniciar while ocupado=1: ignored; no restart, no glitch on outputs.
- reset asserted mid-handshake: valid drops immediately (asynchronously) and all state clears. The controller must treat this as no request.
- The first request after CICLICO wrap reads address 0 again; emitidos keeps counting.
- A queue code of 00 (floor -1) is a normal destination, not "empty".

Decomposition:
- Shared package holds:
  - floor-code constants PISO_MENOS_UNO=2'b00, PISO_UNO=2'b01, PISO_DOS=2'b10, PISO_TRES=2'b11, so the queue and the controller share the same encoding;
  - the FSM state encoding IDLE, LEER, OFRECER, ESPERA, FIN.
- One natural sub-module: contador_intervalo (loadable down-counter with zero flag), reused later for door-open timing.

Test Plan:
- Reset then iniciar, destino_ready tied 1, queue contents 11,11,10,01,11,01,00,10,11,01 -> 10 handshakes carry exactly that code sequence, each separated by INTERVALO=50 idle cycles; fin=1 after the 10th; emitidos=10.
- destino_ready held 0 for 7 cycles in OFRECER at address 3 -> destino_valid stays 1, destino_piso stays 01, address stays 3 for all 7 cycles; handshake completes on the cycle ready rises.
- CICLICO=1, ready tied 1 -> after address 9 the next read is address 0 (code 11); fin never asserts; emitidos=11 after the 11th handshake.
- iniciar pulsed while in ESPERA at address 5 -> no restart; sequence continues to address 6 unchanged.
- reset asserted asynchronously while destino_valid=1 at address 4 -> valid, address, emitidos all 0 before the next clock edge; state IDLE; next iniciar restarts from address 0.
- Entry 6 (code 00) -> issued as destino_piso=00 with valid=1; the sequence continues normally.

Source files
------------

// File: rtl/despachador_destinos_externos_pkg.sv
// Shared definitions for the external-destination dispatcher.
// - Floor-code constants shared by the destination queue and the elevator controller.
// - FSM state encoding of the dispatcher.
// - Helper that tells whether a state counts as busy.
package despachador_destinos_externos_pkg;

  // Floor codes as stored in the queue and driven on destino_piso.
  localparam logic [1:0] PISO_MENOS_UNO = 2'b00;
  localparam logic [1:0] PISO_UNO       = 2'b01;
  localparam logic [1:0] PISO_DOS       = 2'b10;
  localparam logic [1:0] PISO_TRES      = 2'b11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LEER    = 3'd1,
    OFRECER = 3'd2,
    ESPERA  = 3'd3,
    FIN     = 3'd4
  } estado_t;

  // Busy in every state except the two resting states.
  function automatic logic estado_ocupado(input estado_t e);
    return (e != IDLE) && (e != FIN);
  endfunction

endpackage

// File: rtl/despachador_destinos_externos_contador_intervalo.sv
// Loadable down-counter with zero flag.
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous, active-high reset (count clears to 0)
//   i_carga      load i_valor into the count (has priority over decrement)
//   i_valor      value to load
//   i_decrementar decrement by one while the count is non-zero
//   o_cero       high while the count equals 0
module despachador_destinos_externos_contador_intervalo #(
  parameter int unsigned ANCHO = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_carga,
  input  logic [ANCHO-1:0] i_valor,
  input  logic             i_decrementar,
  output logic             o_cero
);

  logic [ANCHO-1:0] r_cuenta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cuenta <= '0;
    end else if (i_carga) begin
      r_cuenta <= i_valor;
    end else if (i_decrementar && (r_cuenta != '0)) begin
      // Stops at zero instead of wrapping.
      r_cuenta <= r_cuenta - ANCHO'(1);
    end
  end

  assign o_cero = (r_cuenta == '0);

endmodule

// File: rtl/despachador_destinos_externos.sv
// Sequencer downstream of the external-destination queue ROM.
// Steps the queue address, paces reads with an inter-request interval and hands each
// 2-bit floor code to the elevator controller over a valid/ready handshake.
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous, active-high reset
//   iniciar        one-cycle start pulse, honoured only in IDLE or FIN
//   address        queue read address
//   dato_cola      floor code from the queue (combinational from address)
//   destino_valid  request valid toward the controller
//   destino_piso   floor code, stable while destino_valid is high
//   destino_ready  controller accepts the request
//   ocupado        high in every state except IDLE and FIN
//   fin            high while in FIN
//   emitidos       completed handshakes since the last start (saturating)
module despachador_destinos_externos
  import despachador_destinos_externos_pkg::*;
#(
  parameter int unsigned NUM_DESTINOS = 10,
  parameter int unsigned INTERVALO    = 50,
  parameter int unsigned CICLICO      = 0,
  parameter int unsigned ADDR_W       = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              iniciar,
  output logic [ADDR_W-1:0] address,
  input  logic [1:0]        dato_cola,
  output logic              destino_valid,
  output logic [1:0]        destino_piso,
  input  logic              destino_ready,
  output logic              ocupado,
  output logic              fin,
  output logic [ADDR_W-1:0] emitidos
);

  localparam int unsigned CNT_W = (INTERVALO > 1) ? $clog2(INTERVALO) : 1;
  localparam logic [ADDR_W-1:0] ULTIMA_DIR = ADDR_W'(NUM_DESTINOS - 1);

  estado_t           r_estado;
  estado_t           w_estado_d;
  logic [ADDR_W-1:0] r_address;
  logic [ADDR_W-1:0] r_emitidos;
  logic [1:0]        r_piso;

  logic w_arranque;
  logic w_handshake;
  logic w_ultima;
  logic w_carga;
  logic w_decrementar;
  logic w_cero;

  assign w_arranque  = ((r_estado == IDLE) || (r_estado == FIN)) && iniciar;
  assign w_handshake = (r_estado == OFRECER) && destino_ready;
  assign w_ultima    = (r_address == ULTIMA_DIR);

  despachador_destinos_externos_contador_intervalo #(
    .ANCHO (CNT_W)
  ) u_contador_intervalo (
    .clk           (clk),
    .reset         (reset),
    .i_carga       (w_carga),
    .i_valor       (CNT_W'(INTERVALO - 1)),
    .i_decrementar (w_decrementar),
    .o_cero        (w_cero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_estado <= IDLE;
    end else begin
      r_estado <= w_estado_d;
    end
  end

  always_comb begin
    w_estado_d    = r_estado;
    w_carga       = 1'b0;
    w_decrementar = 1'b0;
    unique case (r_estado)
      IDLE, FIN: begin
        if (iniciar) begin
          w_estado_d = LEER;
        end
      end
      LEER: begin
        w_estado_d = OFRECER;
      end
      OFRECER: begin
        if (destino_ready) begin
          // Interval starts counting from the cycle after the handshake.
          w_carga = 1'b1;
          if (w_ultima && (CICLICO == 0)) begin
            w_estado_d = FIN;
          end else begin
            w_estado_d = ESPERA;
          end
        end
      end
      ESPERA: begin
        w_decrementar = 1'b1;
        if (w_cero) begin
          w_estado_d = LEER;
        end
      end
      default: begin
        w_estado_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_address  <= '0;
      r_emitidos <= '0;
    end else if (w_arranque) begin
      r_address  <= '0;
      r_emitidos <= '0;
    end else if (w_handshake) begin
      if (r_emitidos != '1) begin
        r_emitidos <= r_emitidos + ADDR_W'(1);
      end
      // Address wraps at the queue length, not at 2^ADDR_W; without wrap it parks on
      // the last entry while in FIN.
      if (!w_ultima) begin
        r_address <= r_address + ADDR_W'(1);
      end else if (CICLICO != 0) begin
        r_address <= '0;
      end
    end
  end

  // Floor code is captured once per request so it stays put while valid is high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_piso <= PISO_MENOS_UNO;
    end else if (r_estado == LEER) begin
      r_piso <= dato_cola;
    end
  end

  assign address       = r_address;
  assign emitidos      = r_emitidos;
  assign destino_piso  = r_piso;
  assign destino_valid = (r_estado == OFRECER);
  assign fin           = (r_estado == FIN);
  assign ocupado       = estado_ocupado(r_estado);

endmodule

// File: tb/tb_despachador_destinos_externos.sv
// Bench for the external-destination dispatcher: one stopping instance and one
// wrapping instance share clock, reset and start, each reads its own copy of the queue.
// A request-level model predicts, per cycle, valid, address, code, count, fin and busy.
module tb_despachador_destinos_externos;

  localparam int unsigned N         = 10;
  localparam int unsigned INTERVALO = 50;
  localparam int unsigned ADDR_W    = 8;

  logic clk = 1'b0;
  logic reset;
  logic iniciar;
  logic [1:0] ready_v;
  logic [1:0] valid_v;
  logic [1:0] fin_v;
  logic [1:0] ocup_v;
  logic [1:0][ADDR_W-1:0] addr_v;
  logic [1:0][ADDR_W-1:0] emit_v;
  logic [1:0][1:0] piso_v;
  logic [1:0][1:0] dato_v;

  logic [1:0] rom [N];

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      dato_v[i] = (int'(addr_v[i]) < N) ? rom[int'(addr_v[i])] : 2'b00;
    end
  end

  despachador_destinos_externos #(
    .NUM_DESTINOS (N),
    .INTERVALO    (INTERVALO),
    .CICLICO      (0),
    .ADDR_W       (ADDR_W)
  ) dut_lineal (
    .clk           (clk),
    .reset         (reset),
    .iniciar       (iniciar),
    .address       (addr_v[0]),
    .dato_cola     (dato_v[0]),
    .destino_valid (valid_v[0]),
    .destino_piso  (piso_v[0]),
    .destino_ready (ready_v[0]),
    .ocupado       (ocup_v[0]),
    .fin           (fin_v[0]),
    .emitidos      (emit_v[0])
  );

  despachador_destinos_externos #(
    .NUM_DESTINOS (N),
    .INTERVALO    (INTERVALO),
    .CICLICO      (1),
    .ADDR_W       (ADDR_W)
  ) dut_ciclico (
    .clk           (clk),
    .reset         (reset),
    .iniciar       (iniciar),
    .address       (addr_v[1]),
    .dato_cola     (dato_v[1]),
    .destino_valid (valid_v[1]),
    .destino_piso  (piso_v[1]),
    .destino_ready (ready_v[1]),
    .ocupado       (ocup_v[1]),
    .fin           (fin_v[1]),
    .emitidos      (emit_v[1])
  );

  int n_vectores = 0;
  int n_fallos   = 0;
  int g_ciclo    = 0;

  // Request-level model: handshakes done, running flag, finished flag and the cycle in
  // which the next request becomes valid.
  int m_k      [2];
  bit m_activo [2];
  bit m_fin    [2];
  int m_next   [2];

  task automatic comparar(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    n_vectores++;
    if (obs !== esp) begin
      n_fallos++;
      $display("FAIL %s: observado=%0d esperado=%0d (ciclo %0d)", tag, obs, esp, g_ciclo);
    end
  endtask

  task automatic reset_modelo();
    for (int i = 0; i < 2; i++) begin
      m_k[i]      = 0;
      m_activo[i] = 1'b0;
      m_fin[i]    = 1'b0;
      m_next[i]   = 0;
    end
  endtask

  function automatic bit valido_proximo(input int i);
    return m_activo[i] && ((g_ciclo + 1) >= m_next[i]);
  endfunction

  // One cycle: check outputs mid-cycle, then drive inputs sampled at the next edge.
  task automatic paso(input logic ini, input logic r0, input logic r1);
    logic [1:0] rdy;
    bit pre;
    bit ev;
    int ea;
    rdy = {r1, r0};
    @(negedge clk);
    g_ciclo++;
    for (int i = 0; i < 2; i++) begin
      ev = m_activo[i] && (g_ciclo >= m_next[i]);
      ea = m_fin[i] ? int'(N) - 1 : m_k[i] % int'(N);
      comparar($sformatf("valid%0d", i), 32'(valid_v[i]), 32'(ev));
      comparar($sformatf("address%0d", i), 32'(addr_v[i]), 32'(ea));
      comparar($sformatf("emitidos%0d", i), 32'(emit_v[i]), 32'((m_k[i] > 255) ? 255 : m_k[i]));
      comparar($sformatf("fin%0d", i), 32'(fin_v[i]), 32'(m_fin[i]));
      comparar($sformatf("ocupado%0d", i), 32'(ocup_v[i]), 32'(m_activo[i]));
      if (ev) begin
        comparar($sformatf("piso%0d", i), 32'(piso_v[i]), 32'(rom[ea]));
      end
      pre = m_activo[i];
      if (ev && rdy[i]) begin
        m_k[i]++;
        if ((i == 0) && (m_k[i] == int'(N))) begin
          m_activo[i] = 1'b0;
          m_fin[i]    = 1'b1;
        end else begin
          // INTERVALO idle cycles, one read cycle, then the next offer.
          m_next[i] = g_ciclo + int'(INTERVALO) + 2;
        end
      end
      if (ini && !pre) begin
        m_activo[i] = 1'b1;
        m_fin[i]    = 1'b0;
        m_k[i]      = 0;
        m_next[i]   = g_ciclo + 2;
      end
    end
    iniciar = ini;
    ready_v = rdy;
  endtask

  task automatic hacer_reset();
    @(negedge clk);
    reset   = 1'b1;
    iniciar = 1'b0;
    ready_v = 2'b00;
    @(negedge clk);
    reset = 1'b0;
    g_ciclo += 2;
    reset_modelo();
  endtask

  task automatic plazo(input string tag, input int usado, input int limite);
    if (usado >= limite) begin
      n_fallos++;
      $display("FAIL plazo_%s: ciclos=%0d limite=%0d", tag, usado, limite);
    end
  endtask

  initial begin
    int b;
    int ret;
    bit pulsado;
    logic [1:0] tabla [N];
    tabla = '{2'b11, 2'b11, 2'b10, 2'b01, 2'b11, 2'b01, 2'b00, 2'b10, 2'b11, 2'b01};
    rom     = tabla;
    iniciar = 1'b0;
    ready_v = 2'b00;
    reset   = 1'b1;
    reset_modelo();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Idle after reset; ready alone must not provoke anything.
    repeat (3) paso(1'b0, 1'b1, 1'b1);

    // Run 1: ready tied high, fixed queue contents.
    paso(1'b1, 1'b1, 1'b1);
    b = 0;
    while ((m_k[1] < 11 || !m_fin[0]) && b < 800) begin
      paso(1'b0, 1'b1, 1'b1);
      b++;
    end
    plazo("run1", b, 800);
    paso(1'b0, 1'b0, 1'b0);
    comparar("emitidos_final_lineal", 32'(emit_v[0]), 32'd10);
    comparar("fin_final_lineal", 32'(fin_v[0]), 32'd1);
    comparar("addr_final_lineal", 32'(addr_v[0]), 32'd9);
    comparar("emitidos_final_ciclico", 32'(emit_v[1]), 32'd11);
    comparar("fin_final_ciclico", 32'(fin_v[1]), 32'd0);

    // Run 2: stall 7 cycles at address 3, start pulse while waiting at address 5.
    hacer_reset();
    paso(1'b1, 1'b0, 1'b0);
    b = 0;
    ret = 0;
    pulsado = 1'b0;
    while (!m_fin[0] && b < 1000) begin
      logic r0;
      logic ini;
      ini = 1'b0;
      r0  = ($urandom_range(0, 3) != 0);
      if (valido_proximo(0) && m_k[0] == 3 && ret < 7) begin
        r0 = 1'b0;
        ret++;
      end else if (valido_proximo(0) && m_k[0] == 3) begin
        r0 = 1'b1;
      end
      if (!pulsado && m_activo[0] && !valido_proximo(0) && m_k[0] == 5) begin
        ini     = 1'b1;
        pulsado = 1'b1;
      end
      paso(ini, r0, ($urandom_range(0, 1) != 0));
      b++;
    end
    plazo("run2", b, 1000);
    paso(1'b0, 1'b0, 1'b0);
    comparar("emitidos_run2", 32'(emit_v[0]), 32'd10);

    // Run 3: random queue, asynchronous reset while offering address 4, then restart.
    for (int j = 0; j < int'(N); j++) rom[j] = 2'($urandom_range(0, 3));
    hacer_reset();
    paso(1'b1, 1'b0, 1'b0);
    b = 0;
    while (!(valido_proximo(0) && m_k[0] == 4) && b < 600) begin
      paso(1'b0, 1'b1, ($urandom_range(0, 1) != 0));
      b++;
    end
    plazo("run3a", b, 600);
    @(negedge clk);
    g_ciclo++;
    comparar("valid_antes_reset", 32'(valid_v[0]), 32'd1);
    comparar("addr_antes_reset", 32'(addr_v[0]), 32'd4);
    #2 reset = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      comparar($sformatf("rst_valid%0d", i), 32'(valid_v[i]), 32'd0);
      comparar($sformatf("rst_address%0d", i), 32'(addr_v[i]), 32'd0);
      comparar($sformatf("rst_emitidos%0d", i), 32'(emit_v[i]), 32'd0);
      comparar($sformatf("rst_piso%0d", i), 32'(piso_v[i]), 32'd0);
      comparar($sformatf("rst_fin%0d", i), 32'(fin_v[i]), 32'd0);
      comparar($sformatf("rst_ocupado%0d", i), 32'(ocup_v[i]), 32'd0);
    end
    iniciar = 1'b0;
    ready_v = 2'b00;
    @(negedge clk);
    reset = 1'b0;
    g_ciclo++;
    reset_modelo();
    paso(1'b0, 1'b0, 1'b0);
    paso(1'b1, 1'b0, 1'b0);
    b = 0;
    while (!m_fin[0] && b < 1200) begin
      paso(1'b0, ($urandom_range(0, 2) != 0), ($urandom_range(0, 2) != 0));
      b++;
    end
    plazo("run3b", b, 1200);

    // Run 4: long wrapping run so the handshake count saturates.
    hacer_reset();
    paso(1'b1, 1'b1, 1'b1);
    b = 0;
    while (m_k[1] < 258 && b < 15000) begin
      paso(($urandom_range(0, 7) == 0), 1'b1, 1'b1);
      b++;
    end
    plazo("run4", b, 15000);
    paso(1'b0, 1'b0, 1'b0);
    comparar("emitidos_saturado", 32'(emit_v[1]), 32'd255);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectores, n_fallos);
    $finish;
  end

endmodule
